vwiden_stream: RTL and testbench
================================

VWIDEN_STREAM -- requirements
Module: vwiden_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the operand/result width; legal values are powers of two from 64 to 1024.
REQ-002 Parameter BE_WIDTH, default DATA_WIDTH/8, SHALL be the byte-enable width.
REQ-003 Parameter SEW_WIDTH, default 2, SHALL be the element-width code width.
REQ-004 Parameter SKIP_EMPTY_HI, default 1, SHALL enable suppression of an all-disabled upper beat (REQ-017).
REQ-005 Ports SHALL be:
  clk  input  1  clock, all state updates on its rising edge.
  rst  input  1  asynchronous, active-high reset.
  in_valid  input  1  request beat valid.
  in_ready  output  1  request beat accepted when in_valid & in_ready.
  in_vec0, in_vec1  input  DATA_WIDTH  narrow operands.
  in_be  input  BE_WIDTH  narrow byte enables.
  in_sew  input  SEW_WIDTH  source element width: 0=8b, 1=16b, 2=32b, 3=64b.
  in_signed  input  1  1=sign-extend, 0=zero-extend.
  out_valid  output  1  result beat valid.
  out_ready  input  1  result beat consumed when out_valid & out_ready.
  out_vec0, out_vec1  output  DATA_WIDTH  widened operands.
  out_be  output  BE_WIDTH  widened byte enables.
  out_sew  output  SEW_WIDTH  destination element width.
  out_last  output  1  final result beat of the current request.

Function
REQ-006 Each accepted request with in_sew<3 SHALL produce two result beats, in order: LO (source bits [DATA_WIDTH/2-1:0]), then HI (source bits [DATA_WIDTH-1:DATA_WIDTH/2]).
REQ-007 In each beat, every source element of width 8<<in_sew in the selected half SHALL occupy a 2x-wide destination slot at the same element index, extended by its MSB when in_signed=1, by zeros otherwise; vec0 and vec1 are processed identically.
REQ-008 out_be bit 2k and 2k+1 SHALL each equal the selected-half in_be bit k.
REQ-009 out_sew SHALL equal the registered in_sew+1 for in_sew<3.
REQ-010 in_sew=3 SHALL produce one beat with out_vec0/1, out_be equal to the inputs, out_sew=3, out_last=1.
REQ-011 All request fields SHALL be captured into registers on acceptance; outputs SHALL depend only on registered state and be stable while out_valid & !out_ready.
REQ-012 State machine SHALL have states IDLE, LO, HI: IDLE->LO on acceptance; LO->HI on LO consumption when a HI beat is required; LO->IDLE or HI->IDLE on consumption of the last beat, unless a new request is accepted in the same cycle (->LO).
REQ-013 in_ready SHALL be 1 in IDLE, and in LO/HI exactly when out_ready=1 and the current beat is the last, giving back-to-back throughput with no bubble.
REQ-014 Latency: a request accepted in cycle N SHALL present its LO beat with out_valid=1 in cycle N+1.
REQ-015 out_valid SHALL be 1 in LO and HI and 0 in IDLE; out_last SHALL be 1 only on the final beat.
REQ-016 An out_valid beat SHALL never be withdrawn or changed before it is consumed.
REQ-017 When SKIP_EMPTY_HI=1 and the upper half of captured in_be is all zero, the request SHALL produce the LO beat only, with out_last=1.
REQ-018 An all-zero lower-half in_be SHALL still produce a LO beat with out_be=0; it is not skipped.

Reset
REQ-019 While rst=1: state=IDLE, out_valid=0, out_last=0, in_ready=0, and all data, byte-enable and sew registers =0.
REQ-020 Reset asserted mid-request SHALL discard that request with no further beats; the first cycle after deassertion SHALL have in_ready=1.

Structure
REQ-021 State encoding and SEW code constants (SEW8=0, SEW16=1, SEW32=2, SEW64=3) SHALL reside in shared package vlite_pkg.
REQ-022 The half-select/extend datapath SHALL be one combinational sub-module, vwiden_half, instantiated once per operand with (half, sew, signed) as inputs.

Verification (DATA_WIDTH=64)
REQ-023 sew=0, signed=1, vec0=0x0000_0000_8001_7F80, be=0xFF -> LO 0xFF80_0001_007F_FF80 with be=0xFF, then HI 0x0, out_last=1, out_sew=1.
REQ-024 Same stimulus with signed=0 -> LO 0x0080_0001_007F_0080.
REQ-025 sew=2, signed=1, vec1=0x8000_0000_0000_0001 -> LO 0x0000_0000_0000_0001, then HI 0xFFFF_FFFF_8000_0000, out_sew=3.
REQ-026 be=0x0F, SKIP_EMPTY_HI=1 -> single LO beat with out_be=0xFF and out_last=1; next request accepted in that same cycle if presented.
REQ-027 out_ready held low 3 cycles during LO -> outputs stable, in_ready=0; then two back-to-back requests with out_ready=1 -> four beats on consecutive cycles.
REQ-028 rst pulsed while in HI -> out_valid=0 immediately, no HI beat afterward, in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/vlite_pkg.sv
// Shared definitions for the vector-lite stream blocks: FSM encoding and element-width codes.
package vlite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    localparam logic [1:0] SEW8  = 2'd0;
    localparam logic [1:0] SEW16 = 2'd1;
    localparam logic [1:0] SEW32 = 2'd2;
    localparam logic [1:0] SEW64 = 2'd3;

    // 64-bit elements cannot widen further, so they keep their own code.
    function automatic logic [1:0] widen_sew(input logic [1:0] sew);
        return (sew == SEW64) ? SEW64 : sew + 2'd1;
    endfunction

endpackage

// File: rtl/vwiden_half.sv
// Selects one half of a narrow operand and sign/zero-extends each element into a 2x-wide slot.
module vwiden_half
    import vlite_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] src,
    input  logic                  half,
    input  logic [1:0]            sew,
    input  logic                  is_signed,
    output logic [DATA_WIDTH-1:0] dst
);

    localparam int HALF_WIDTH = DATA_WIDTH / 2;

    logic [HALF_WIDTH-1:0] half_bits;

    assign half_bits = half ? src[DATA_WIDTH-1:HALF_WIDTH] : src[HALF_WIDTH-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dst = '0;
        case (sew)
            SEW8: begin
                for (int i = 0; i < DATA_WIDTH / 16; i++)
                    dst[16*i +: 16] = {{8{is_signed & half_bits[8*i+7]}}, half_bits[8*i +: 8]};
            end
            SEW16: begin
                for (int i = 0; i < DATA_WIDTH / 32; i++)
                    dst[32*i +: 32] = {{16{is_signed & half_bits[16*i+15]}}, half_bits[16*i +: 16]};
            end
            SEW32: begin
                for (int i = 0; i < DATA_WIDTH / 64; i++)
                    dst[64*i +: 64] = {{32{is_signed & half_bits[32*i+31]}}, half_bits[32*i +: 32]};
            end
            default: dst = src;
        endcase
    end

endmodule

// File: rtl/vwiden_stream.sv
// Streaming vector widener: each request becomes a LO and (usually) a HI result beat with doubled SEW.
module vwiden_stream
    import vlite_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int BE_WIDTH      = DATA_WIDTH / 8,
    parameter int SEW_WIDTH     = 2,
    parameter int SKIP_EMPTY_HI = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_vec0,
    input  logic [DATA_WIDTH-1:0] in_vec1,
    input  logic [BE_WIDTH-1:0]   in_be,
    input  logic [SEW_WIDTH-1:0]  in_sew,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_vec0,
    output logic [DATA_WIDTH-1:0] out_vec1,
    output logic [BE_WIDTH-1:0]   out_be,
    output logic [SEW_WIDTH-1:0]  out_sew,
    output logic                  out_last
);

    localparam int BE_HALF = BE_WIDTH / 2;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] vec0_q, vec1_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [SEW_WIDTH-1:0]  sew_q;
    logic                  signed_q;

    logic                  accept, consume, need_hi, is_wide64;
    logic [BE_HALF-1:0]    be_half;
    logic [BE_WIDTH-1:0]   be_wide;

    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign is_wide64 = (sew_q == SEW_WIDTH'(SEW64));
    // An empty upper byte-enable half makes the HI beat pointless when skipping is enabled.
    assign need_hi   = !is_wide64 &&
                       !((SKIP_EMPTY_HI != 0) && (be_q[BE_WIDTH-1:BE_HALF] == '0));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec0_q   <= '0;
            vec1_q   <= '0;
            be_q     <= '0;
            sew_q    <= '0;
            signed_q <= 1'b0;
        end else if (accept) begin
            vec0_q   <= in_vec0;
            vec1_q   <= in_vec1;
            be_q     <= in_be;
            sew_q    <= in_sew;
            signed_q <= in_signed;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_LO;
            ST_LO: begin
                if (consume) begin
                    if (need_hi)     state_next = ST_HI;
                    else if (accept) state_next = ST_LO;
                    else             state_next = ST_IDLE;
                end
            end
            ST_HI: begin
                if (consume) state_next = accept ? ST_LO : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == ST_LO) || (state == ST_HI);
        out_last  = (state == ST_HI) || ((state == ST_LO) && !need_hi);
        // Accepting is only safe once the final beat of the current request is leaving.
        in_ready  = !rst && ((state == ST_IDLE) || (out_ready && out_last));
    end

    always_comb begin
        be_half = (state == ST_HI) ? be_q[BE_WIDTH-1:BE_HALF] : be_q[BE_HALF-1:0];
        be_wide = '0;
        for (int k = 0; k < BE_HALF; k++)
            be_wide[2*k +: 2] = {2{be_half[k]}};
    end

    assign out_be  = is_wide64 ? be_q : be_wide;
    assign out_sew = out_valid ? SEW_WIDTH'(widen_sew(sew_q[1:0])) : '0;

    vwiden_half #(.DATA_WIDTH(DATA_WIDTH)) u_half_vec0 (
        .src       (vec0_q),
        .half      (state == ST_HI),
        .sew       (sew_q[1:0]),
        .is_signed (signed_q),
        .dst       (out_vec0)
    );

    vwiden_half #(.DATA_WIDTH(DATA_WIDTH)) u_half_vec1 (
        .src       (vec1_q),
        .half      (state == ST_HI),
        .sew       (sew_q[1:0]),
        .is_signed (signed_q),
        .dst       (out_vec1)
    );

endmodule

// File: tb/tb_vwiden_stream.sv
// Directed bench for vwiden_stream at DATA_WIDTH=64 with hand-computed expected beats.
module tb_vwiden_stream;

    typedef logic [139:0] beat_t;  // {valid, last, sew[1:0], be[7:0], vec0[63:0], vec1[63:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_vec0 = '0;
    logic [63:0] in_vec1 = '0;
    logic [7:0]  in_be = '0;
    logic [1:0]  in_sew = '0;
    logic        in_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_vec0, out_vec1;
    logic [7:0]  out_be;
    logic [1:0]  out_sew;
    logic        out_last;

    int n_cmp = 0;
    int n_err = 0;
    beat_t obs, exp;

    vwiden_stream #(.DATA_WIDTH(64), .BE_WIDTH(8), .SEW_WIDTH(2), .SKIP_EMPTY_HI(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec0   (in_vec0),
        .in_vec1   (in_vec1),
        .in_be     (in_be),
        .in_sew    (in_sew),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec0  (out_vec0),
        .out_vec1  (out_vec1),
        .out_be    (out_be),
        .out_sew   (out_sew),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic beat_t snap();
        return {out_valid, out_last, out_sew, out_be, out_vec0, out_vec1};
    endfunction

    function automatic beat_t beat(input logic v, input logic l, input logic [1:0] s,
                                   input logic [7:0] be, input logic [63:0] v0, input logic [63:0] v1);
        return {v, l, s, be, v0, v1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] v0, input logic [63:0] v1, input logic [7:0] be,
                         input logic [1:0] sew, input logic sgn);
        in_vec0 = v0; in_vec1 = v1; in_be = be; in_sew = sew; in_signed = sgn;
        in_valid = 1'b1;
    endtask

    // Presents a request and returns in the cycle after acceptance (the LO beat cycle).
    task automatic send_req(input logic [63:0] v0, input logic [63:0] v1, input logic [7:0] be,
                            input logic [1:0] sew, input logic sgn);
        int waited = 0;
        drive(v0, v1, be, sew, sgn);
        while (in_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_cmp++;
        if (waited >= 20) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waited);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        obs = snap(); exp = '0; n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL reset_outputs: got %h want %h", obs, exp); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++; $display("FAIL reset_release: ready/valid got %b want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_sew8(input logic sgn, input logic [63:0] lo0, input logic [63:0] hi1, input string tag);
        out_ready = 1'b1;
        send_req(64'h0000_0000_8001_7F80, 64'h0000_00FF_0000_0000, 8'hFF, 2'd0, sgn);
        obs = snap(); exp = beat(1'b1, 1'b0, 2'd1, 8'hFF, lo0, 64'h0); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL %s_lo: got %h want %h", tag, obs, exp); end
        step();
        obs = snap(); exp = beat(1'b1, 1'b1, 2'd1, 8'hFF, 64'h0, hi1); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL %s_hi: got %h want %h", tag, obs, exp); end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_idle: out_valid got %b want 0", tag, out_valid); end
    endtask

    task automatic test_sew16_be();
        send_req(64'h8000_7FFF_1234_FFFE, 64'h0, 8'hA5, 2'd1, 1'b1);
        obs = snap(); exp = beat(1'b1, 1'b0, 2'd2, 8'h33, 64'h0000_1234_FFFF_FFFE, 64'h0); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL sew16_lo: got %h want %h", obs, exp); end
        step();
        obs = snap(); exp = beat(1'b1, 1'b1, 2'd2, 8'hCC, 64'hFFFF_8000_0000_7FFF, 64'h0); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL sew16_hi: got %h want %h", obs, exp); end
        step();
    endtask

    task automatic test_sew32_signed();
        send_req(64'h0, 64'h8000_0000_0000_0001, 8'hFF, 2'd2, 1'b1);
        obs = snap(); exp = beat(1'b1, 1'b0, 2'd3, 8'hFF, 64'h0, 64'h0000_0000_0000_0001); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL sew32_lo: got %h want %h", obs, exp); end
        step();
        obs = snap(); exp = beat(1'b1, 1'b1, 2'd3, 8'hFF, 64'h0, 64'hFFFF_FFFF_8000_0000); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL sew32_hi: got %h want %h", obs, exp); end
        step();
    endtask

    task automatic test_sew64_passthrough();
        send_req(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 8'h3C, 2'd3, 1'b1);
        obs = snap(); exp = beat(1'b1, 1'b1, 2'd3, 8'h3C, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL sew64_beat: got %h want %h", obs, exp); end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL sew64_single: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_lo_be_zero();
        send_req(64'h0102_0304_0506_0708, 64'h0, 8'hF0, 2'd0, 1'b0);
        obs = snap(); exp = beat(1'b1, 1'b0, 2'd1, 8'h00, 64'h0005_0006_0007_0008, 64'h0); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL lobe0_lo: got %h want %h", obs, exp); end
        step();
        obs = snap(); exp = beat(1'b1, 1'b1, 2'd1, 8'hFF, 64'h0001_0002_0003_0004, 64'h0); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL lobe0_hi: got %h want %h", obs, exp); end
        step();
    endtask

    task automatic test_skip_hi();
        send_req(64'hFFFF_FFFF_0000_00FF, 64'h0, 8'h0F, 2'd0, 1'b1);
        obs = snap(); exp = beat(1'b1, 1'b1, 2'd1, 8'hFF, 64'h0000_0000_0000_FFFF, 64'h0); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL skip_lo: got %h want %h", obs, exp); end
        drive(64'hAAAA_AAAA_BBBB_BBBB, 64'h0, 8'hFF, 2'd2, 1'b0);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL skip_in_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        obs = snap(); exp = beat(1'b1, 1'b0, 2'd3, 8'hFF, 64'h0000_0000_BBBB_BBBB, 64'h0); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL skip_next_lo: got %h want %h", obs, exp); end
        step();
        obs = snap(); exp = beat(1'b1, 1'b1, 2'd3, 8'hFF, 64'h0000_0000_AAAA_AAAA, 64'h0); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL skip_next_hi: got %h want %h", obs, exp); end
        step();
    endtask

    task automatic test_back_to_back();
        beat_t lo_a;
        out_ready = 1'b0;
        send_req(64'h1111_1111_2222_2222, 64'h0, 8'hFF, 2'd2, 1'b0);
        lo_a = beat(1'b1, 1'b0, 2'd3, 8'hFF, 64'h0000_0000_2222_2222, 64'h0);
        drive(64'h3333_3333_4444_4444, 64'h0, 8'hFF, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            obs = snap(); n_cmp++;
            if (obs !== lo_a || in_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_%0d: got %h ready %b want %h ready 0", i, obs, in_ready, lo_a);
            end
            if (i < 3) step();
        end
        out_ready = 1'b1;
        step();
        obs = snap(); exp = beat(1'b1, 1'b1, 2'd3, 8'hFF, 64'h0000_0000_1111_1111, 64'h0); n_cmp++;
        if (obs !== exp || in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_a_hi: got %h ready %b want %h ready 1", obs, in_ready, exp);
        end
        step();
        drive(64'h5555_5555_6666_6666, 64'h0, 8'hFF, 2'd2, 1'b0);
        obs = snap(); exp = beat(1'b1, 1'b0, 2'd3, 8'hFF, 64'h0000_0000_4444_4444, 64'h0); n_cmp++;
        if (obs !== exp || in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_b_lo: got %h ready %b want %h ready 0", obs, in_ready, exp);
        end
        step();
        obs = snap(); exp = beat(1'b1, 1'b1, 2'd3, 8'hFF, 64'h0000_0000_3333_3333, 64'h0); n_cmp++;
        if (obs !== exp || in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_b_hi: got %h ready %b want %h ready 1", obs, in_ready, exp);
        end
        step();
        in_valid = 1'b0;
        obs = snap(); exp = beat(1'b1, 1'b0, 2'd3, 8'hFF, 64'h0000_0000_6666_6666, 64'h0); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL b2b_c_lo: got %h want %h", obs, exp); end
        step();
        obs = snap(); exp = beat(1'b1, 1'b1, 2'd3, 8'hFF, 64'h0000_0000_5555_5555, 64'h0); n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL b2b_c_hi: got %h want %h", obs, exp); end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_request();
        send_req(64'h0000_0000_8001_7F80, 64'h0, 8'hFF, 2'd0, 1'b1);
        step();
        n_cmp++;
        if ({out_valid, out_last} !== 2'b11) begin
            n_err++; $display("FAIL rstmid_in_hi: valid/last got %b want 11", {out_valid, out_last});
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_last, in_ready} !== 3'b000) begin
            n_err++; $display("FAIL rstmid_assert: valid/last/ready got %b want 000", {out_valid, out_last, in_ready});
        end
        step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++; $display("FAIL rstmid_release: ready/valid got %b want 10", {in_ready, out_valid});
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_hi: out_valid got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_sew8(1'b1, 64'hFF80_0001_007F_FF80, 64'h0000_0000_0000_FFFF, "sew8_signed");
        test_sew8(1'b0, 64'h0080_0001_007F_0080, 64'h0000_0000_0000_00FF, "sew8_unsigned");
        test_sew16_be();
        test_sew32_signed();
        test_sew64_passthrough();
        test_lo_be_zero();
        test_skip_hi();
        test_back_to_back();
        test_reset_mid_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
